// File: rtl/alu_multicycle.sv
// Execute ALU with single-cycle logic/shift/compare ops and iterative RV32M
// multiply (shift-add) and divide (restoring), behind valid/ready handshakes.
module alu_multicycle #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             zero
);

   localparam logic [4:0] OP_ADD    = 5'd0;
   localparam logic [4:0] OP_SUB    = 5'd1;
   localparam logic [4:0] OP_AND    = 5'd2;
   localparam logic [4:0] OP_OR     = 5'd3;
   localparam logic [4:0] OP_XOR    = 5'd4;
   localparam logic [4:0] OP_SLL    = 5'd5;
   localparam logic [4:0] OP_SRL    = 5'd6;
   localparam logic [4:0] OP_SRA    = 5'd7;
   localparam logic [4:0] OP_SLT    = 5'd8;
   localparam logic [4:0] OP_SLTU   = 5'd9;
   localparam logic [4:0] OP_MUL    = 5'd10;
   localparam logic [4:0] OP_MULH   = 5'd11;
   localparam logic [4:0] OP_MULHSU = 5'd12;
   localparam logic [4:0] OP_MULHU  = 5'd13;
   localparam logic [4:0] OP_DIV    = 5'd14;
   localparam logic [4:0] OP_DIVU   = 5'd15;
   localparam logic [4:0] OP_REM    = 5'd16;
   localparam logic [4:0] OP_REMU   = 5'd17;

   localparam logic [SHW:0] LAST = (SHW+1)'(WIDTH);

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   function automatic logic [WIDTH-1:0] simple_op(input logic [4:0] f,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
      logic signed [WIDTH-1:0] xs;
      logic signed [WIDTH-1:0] ys;
      logic [SHW-1:0]          sh;
      xs = x;
      ys = y;
      sh = y[SHW-1:0];
      case (f)
         OP_ADD:  simple_op = x + y;
         OP_SUB:  simple_op = x - y;
         OP_AND:  simple_op = x & y;
         OP_OR:   simple_op = x | y;
         OP_XOR:  simple_op = x ^ y;
         OP_SLL:  simple_op = x << sh;
         OP_SRL:  simple_op = x >> sh;
         OP_SRA:  simple_op = xs >>> sh;
         OP_SLT:  simple_op = {{(WIDTH-1){1'b0}}, (xs < ys)};
         OP_SLTU: simple_op = {{(WIDTH-1){1'b0}}, (x < y)};
         default: simple_op = '0;
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] fix_sign(input logic neg, input logic [WIDTH-1:0] x);
      fix_sign = neg ? -x : x;
   endfunction

   function automatic logic [2*WIDTH-1:0] fix_sign_wide(input logic neg,
                                                       input logic [2*WIDTH-1:0] x);
      fix_sign_wide = neg ? -x : x;
   endfunction

   state_t             state, state_nx;
   logic [SHW:0]       cnt;
   logic               accept, done, iterate;
   logic               is_mul, is_div, is_simple;
   logic               sgn_a, sgn_b, neg_a, neg_b;
   logic [WIDTH-1:0]   mag_a, mag_b, simple_res, fin_res;

   logic [4:0]         op_p0;
   logic [WIDTH-1:0]   a_p0;
   logic               neg_p0, nega_p0, dz_p0;
   logic [2*WIDTH-1:0] mcand_p0, acc_p0;
   logic [WIDTH-1:0]   mplier_p0, quo_p0, rem_p0, dvsr_p0;

   logic [WIDTH:0]     div_sh;
   logic               div_ge;
   logic [WIDTH-1:0]   div_sub;
   logic [2*WIDTH-1:0] prod;

   assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready && !flush;
   assign done      = (state != IDLE) && (cnt == LAST);
   assign iterate   = (state != IDLE) && (cnt != LAST);

   assign is_mul    = (op >= OP_MUL) && (op <= OP_MULHU);
   assign is_div    = (op >= OP_DIV) && (op <= OP_REMU);
   assign is_simple = !is_mul && !is_div;

   // Operand signedness decides which inputs are converted to magnitudes
   assign sgn_a = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                  (op == OP_DIV) || (op == OP_REM);
   assign sgn_b = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   assign neg_a = sgn_a && a[WIDTH-1];
   assign neg_b = sgn_b && b[WIDTH-1];
   assign mag_a = fix_sign(neg_a, a);
   assign mag_b = fix_sign(neg_b, b);

   assign simple_res = simple_op(op, a, b);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept && is_mul)      state_nx = MUL;
            else if (accept && is_div) state_nx = DIV;
         end
         MUL, DIV: begin
            if (cnt == LAST) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (flush) state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     cnt <= '0;
      else if (flush || accept || done) cnt <= '0;
      else if (iterate)               cnt <= cnt + (SHW+1)'(1);
   end

   // Restoring divide step: shift in next dividend bit, subtract if it fits
   assign div_sh  = {rem_p0, quo_p0[WIDTH-1]};
   assign div_ge  = div_sh >= {1'b0, dvsr_p0};
   assign div_sub = div_sh[WIDTH-1:0] - dvsr_p0;

   // Stage p0: operands captured at accept, then iterated in place
   always_ff @(posedge clk) begin
      if (accept) begin
         op_p0     <= op;
         a_p0      <= a;
         neg_p0    <= neg_a ^ neg_b;
         nega_p0   <= neg_a;
         dz_p0     <= (b == '0);
         mcand_p0  <= {{WIDTH{1'b0}}, mag_a};
         mplier_p0 <= mag_b;
         acc_p0    <= '0;
         quo_p0    <= mag_a;
         rem_p0    <= '0;
         dvsr_p0   <= mag_b;
      end else if (iterate && (state == MUL)) begin
         if (mplier_p0[0]) acc_p0 <= acc_p0 + mcand_p0;
         mcand_p0  <= mcand_p0 << 1;
         mplier_p0 <= mplier_p0 >> 1;
      end else if (iterate && (state == DIV)) begin
         rem_p0 <= div_ge ? div_sub : div_sh[WIDTH-1:0];
         quo_p0 <= {quo_p0[WIDTH-2:0], div_ge};
      end
   end

   assign prod = fix_sign_wide(neg_p0, acc_p0);

   always_comb begin
      fin_res = '0;
      case (op_p0)
         OP_MUL:                       fin_res = prod[WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod[2*WIDTH-1:WIDTH];
         OP_DIV, OP_DIVU:              fin_res = dz_p0 ? '1 : fix_sign(neg_p0, quo_p0);
         OP_REM, OP_REMU:              fin_res = dz_p0 ? a_p0 : fix_sign(nega_p0, rem_p0);
         default:                      fin_res = '0;
      endcase
   end

   // Stage p1: result register, held until the consumer takes it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         res       <= '0;
         zero      <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept && is_simple) begin
         out_valid <= 1'b1;
         res       <= simple_res;
         zero      <= (simple_res == '0);
      end else if (done) begin
         out_valid <= 1'b1;
         res       <= fin_res;
         zero      <= (fin_res == '0);
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: directed vectors queued with expected
// result and arrival cycle, checked by an independent output monitor.
module tb_alu_multicycle;
   localparam int W   = 32;
   localparam int LIT = W + 1;

   localparam logic [4:0] ADD = 5'd0,  SUB = 5'd1,  AND_ = 5'd2, OR_ = 5'd3, XOR_ = 5'd4;
   localparam logic [4:0] SLL = 5'd5,  SRL = 5'd6,  SRA = 5'd7,  SLT = 5'd8, SLTU = 5'd9;
   localparam logic [4:0] MUL = 5'd10, MULH = 5'd11, MULHSU = 5'd12, MULHU = 5'd13;
   localparam logic [4:0] DIV = 5'd14, DIVU = 5'd15, REM = 5'd16, REMU = 5'd17;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [4:0]    op = '0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  res;
   logic          zero;

   alu_multicycle #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .res(res), .zero(zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] res;
      int           due;
      string        name;
   } exp_t;
   exp_t sbq[$];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: arrival cycle checked when a result first appears, value at handshake
   bit   prev_ov = 1'b0;
   bit   prev_hs = 1'b0;
   exp_t cur;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ov = 1'b0;
         prev_hs = 1'b0;
      end else begin
         if (out_valid && (!prev_ov || prev_hs)) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result actual=%h required=no result", res);
            end else begin
               cur = sbq[0];
               check({cur.name, "_latency"}, W'(cyc), W'(cur.due));
            end
         end
         if (out_valid && out_ready && sbq.size() != 0) begin
            cur = sbq.pop_front();
            check({cur.name, "_res"}, res, cur.res);
            check({cur.name, "_zero"}, W'(zero), W'(cur.res == '0));
         end
         prev_ov = out_valid;
         prev_hs = out_valid && out_ready;
      end
   end

   // Call just after a rising edge; returns just after the accept edge
   task automatic issue(input string name, input logic [4:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] exp, input bit push,
                        input int lat, output int acc);
      bit ok;
      exp_t e;
      #1;
      in_valid = 1'b1;
      op = o;
      a = x;
      b = y;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      acc = -1;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s_accept_timeout actual=in_ready low required=accept", name);
      end else begin
         acc = cyc + 1;
         if (push) begin
            e.res = exp;
            e.due = acc + lat;
            e.name = name;
            sbq.push_back(e);
         end
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic simp(input string name, input logic [4:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] exp);
      int acc;
      issue(name, o, x, y, exp, 1'b1, 0, acc);
   endtask

   task automatic iter(input string name, input logic [4:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] exp);
      int acc;
      issue(name, o, x, y, exp, 1'b1, LIT, acc);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sbq.size() != 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
   endtask

   task automatic no_result_window(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < LIT + 12; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check(name, W'(seen), '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  acc;
      bit  seen;
      exp_t e;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", W'(out_valid), '0);
      check("rst_res", res, '0);
      check("rst_zero", W'(zero), '0);
      check("rst_in_ready", W'(in_ready), W'(1));
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);

      simp("add_ovf", ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
      simp("sub_zero", SUB, 32'd5, 32'd5, 32'd0);
      simp("sra", SRA, 32'h8000_0000, 32'h24, 32'hF800_0000);
      simp("sltu", SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
      simp("slt", SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
      simp("sll", SLL, 32'd1, 32'h3F, 32'h8000_0000);
      simp("srl", SRL, 32'hF000_0000, 32'd28, 32'h0000_000F);
      simp("and", AND_, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00);
      simp("or", OR_, 32'hFF00_0000, 32'h0000_00FF, 32'hFF00_00FF);
      simp("xor", XOR_, 32'hAAAA_5555, 32'hFFFF_FFFF, 32'h5555_AAAA);
      simp("undef_op", 5'b11111, 32'd5, 32'd6, 32'd0);

      iter("mulh", MULH, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
      iter("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      iter("mul", MUL, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6);
      iter("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);

      iter("div", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      iter("rem", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      iter("divu_by0", DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF);
      iter("remu_by0", REMU, 32'd7, 32'd0, 32'd7);
      iter("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      iter("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      iter("divu", DIVU, 32'd100, 32'd7, 32'd14);
      iter("remu", REMU, 32'd100, 32'd7, 32'd2);
      drain();

      // Result held under backpressure, then released alongside a new accept
      iter("div_hold", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      out_ready = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < LIT + 10; i++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check("hold_arrive", W'(seen), W'(1));
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         check("hold_res", res, 32'hFFFF_FFFD);
         check("hold_valid", W'(out_valid), W'(1));
         check("hold_in_ready", W'(in_ready), '0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      in_valid = 1'b1;
      op = ADD;
      a = 32'd10;
      b = 32'd20;
      @(negedge clk);
      check("b2b_in_ready", W'(in_ready), W'(1));
      e.res = 32'd30;
      e.due = cyc + 1;
      e.name = "b2b_add";
      sbq.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
      drain();

      // Flush mid-multiply
      issue("mul_flushed", MUL, 32'd123, 32'd456, '0, 1'b0, LIT, acc);
      while (cyc < acc + 9) begin
         @(posedge clk);
         #1;
      end
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("flush_in_ready", W'(in_ready), W'(1));
      check("flush_out_valid", W'(out_valid), '0);
      no_result_window("flush_no_result");
      @(posedge clk);
      simp("after_flush", ADD, 32'd1, 32'd2, 32'd3);
      drain();

      // Reset mid-divide
      issue("div_reset", DIV, 32'd1000, 32'd3, '0, 1'b0, LIT, acc);
      while (cyc < acc + 9) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", W'(out_valid), '0);
      check("midrst_res", res, '0);
      check("midrst_zero", W'(zero), '0);
      check("midrst_in_ready", W'(in_ready), W'(1));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      no_result_window("reset_no_result");
      @(posedge clk);
      iter("after_reset", MUL, 32'd12, 32'd11, 32'd132);
      drain();

      check("scoreboard_empty", W'(sbq.size()), '0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
